// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares a single combinational ALU between NREQ requesters.
// Requests are granted round-robin, operands are registered onto the ALU inputs for
// one cycle, and the captured result is held until the owning requester accepts it.
// Optional feature macro: ALU_SHARE_ILLEGAL_OP_EN. When defined, op codes 011/100/101
// bypass the ALU and are answered directly with an error response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_c,
    input  logic                  alu_zero,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_c,
    output logic                  rsp_zero,
    output logic                  rsp_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     rrPtr_q;
    logic [PW-1:0]     owner_q;
    logic [WIDTH-1:0]  aluA_q;
    logic [WIDTH-1:0]  aluB_q;
    logic [2:0]        aluOp_q;
    logic [WIDTH-1:0]  rspC_q;
    logic              rspZero_q;
    logic [NREQ-1:0]   rspValid_q;

    logic              found_d;
    logic [PW-1:0]     winner_d;
    logic [WIDTH-1:0]  winA_d;
    logic [WIDTH-1:0]  winB_d;
    logic [2:0]        winOp_d;
    logic              takeErr_d;

    // Round-robin search starting just after the last winner, wrapping modulo NREQ.
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rrPtr_q) + k) % NREQ;
            if (!found_d && req_valid[idx]) begin
                found_d  = 1'b1;
                winner_d = PW'(idx);
            end
        end
    end

    assign winA_d  = req_a[int'(winner_d)*WIDTH +: WIDTH];
    assign winB_d  = req_b[int'(winner_d)*WIDTH +: WIDTH];
    assign winOp_d = req_op[int'(winner_d)*3 +: 3];

    // Grant is combinational in IDLE; held off during reset so no handshake is lost.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found_d && !reset) begin
            req_ready[winner_d] = 1'b1;
        end
    end

`ifdef ALU_SHARE_ILLEGAL_OP_EN
    logic rspErr_q;

    assign takeErr_d = (winOp_d == 3'b011) || (winOp_d == 3'b100) || (winOp_d == 3'b101);
    assign rsp_err   = rspErr_q;

    // Error flag follows the path chosen at grant time and is held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspErr_q <= 1'b0;
        end else if (state_q == IDLE && found_d) begin
            rspErr_q <= takeErr_d;
        end
    end
`else
    assign takeErr_d = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Main controller: grant/latch in IDLE, capture ALU result in EXEC, hold in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= PW'(NREQ - 1);
            owner_q    <= '0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluOp_q    <= 3'b010;
            rspC_q     <= '0;
            rspZero_q  <= 1'b0;
            rspValid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q <= winner_d;
                        rrPtr_q <= winner_d;
                        if (takeErr_d) begin
                            rspC_q     <= '0;
                            rspZero_q  <= 1'b1;
                            rspValid_q <= ONE << winner_d;
                            state_q    <= RESP;
                        end else begin
                            aluA_q  <= winA_d;
                            aluB_q  <= winB_d;
                            aluOp_q <= winOp_d;
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rspC_q     <= alu_c;
                    rspZero_q  <= alu_zero;
                    rspValid_q <= ONE << owner_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rspValid_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    rspValid_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = aluA_q;
    assign alu_b     = aluB_q;
    assign alu_op    = aluOp_q;
    assign rsp_c     = rspC_q;
    assign rsp_zero  = rspZero_q;
    assign rsp_valid = rspValid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter (WIDTH=32, NREQ=2).
// A behavioural ALU is attached to the shared-ALU port; expected responses are queued
// at grant time and compared when the owning requester sees rsp_valid.
// Honours ALU_SHARE_ILLEGAL_OP_EN when the same macro is defined for the DUT.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] reqA;
    logic [63:0] reqB;
    logic [5:0]  reqOp;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [2:0]  aluOp;
    logic [31:0] aluC;
    logic        aluZero;
    logic [1:0]  rspValid;
    logic [1:0]  rspReady;
    logic [31:0] rspC;
    logic        rspZero;
    logic        rspErr;

    typedef struct {
        int          owner;
        logic [31:0] c;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    alu_share_arbiter #(.WIDTH(32), .NREQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_op    (reqOp),
        .alu_a     (aluA),
        .alu_b     (aluB),
        .alu_op    (aluOp),
        .alu_c     (aluC),
        .alu_zero  (aluZero),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_c     (rspC),
        .rsp_zero  (rspZero),
        .rsp_err   (rspErr)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // The shared ALU the arbiter fronts; undefined op codes return a recognisable marker.
    always_comb begin
        case (aluOp)
            3'b010:  aluC = aluA + aluB;
            3'b110:  aluC = aluA - aluB;
            3'b000:  aluC = aluA & aluB;
            3'b001:  aluC = aluA | aluB;
            3'b111:  aluC = {31'b0, (aluA < aluB)};
            default: aluC = 32'hDEAD_BEEF;
        endcase
    end
    assign aluZero = (aluC == 32'h0);

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        reqA[r*32 +: 32] = a;
        reqB[r*32 +: 32] = b;
        reqOp[r*3 +: 3]  = op;
        reqValid[r]      = 1'b1;
    endtask

    task automatic pushExp(input int r, input logic [31:0] c, input logic z, input logic e);
        exp_t x;
        x.owner = r;
        x.c     = c;
        x.zero  = z;
        x.err   = e;
        sbQ.push_back(x);
    endtask

    task automatic ackResp(input int r);
        rspReady[r] = 1'b1;
        tick();
        rspReady = 2'b00;
    endtask

    // Drive one request, wait (bounded) for grant and then for the response.
    task automatic runOp(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] expC, input logic expZ, input logic expE,
                         output bit granted, output bit responded);
        granted   = 1'b0;
        responded = 1'b0;
        setReq(r, a, b, op);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (reqReady[r]) begin
                granted = 1'b1;
                break;
            end
            tick();
        end
        if (granted) begin
            pushExp(r, expC, expZ, expE);
            tick();
        end
        reqValid[r] = 1'b0;
        if (granted) begin
            for (int i = 0; i < 20; i++) begin
                if (rspValid[r]) begin
                    responded = 1'b1;
                    break;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        reqValid = 2'b11;
        reqA     = '0;
        reqB     = '0;
        reqOp    = '0;
        rspReady = 2'b00;
        tick();
        tick();
        nCompared++; if (reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_req_ready actual=%b required=00", reqReady); end
        nCompared++; if (rspValid !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid actual=%b required=00", rspValid); end
        nCompared++; if (rspC !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rsp_c actual=%h required=0", rspC); end
        nCompared++; if (rspZero !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_zero actual=%b required=0", rspZero); end
        nCompared++; if (rspErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_err actual=%b required=0", rspErr); end
        nCompared++; if (aluA !== 32'h0 || aluB !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_alu_ab actual=%h/%h required=0/0", aluA, aluB); end
        nCompared++; if (aluOp !== 3'b010) begin nMismatched++; $display("[TB] FAIL reset_alu_op actual=%b required=010", aluOp); end
        reqValid = 2'b00;
        reset    = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        exp_t e;
        setReq(0, 32'd5, 32'd3, 3'b010);
        #1;
        nCompared++; if (reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL single_grant actual=%b required=01", reqReady); end
        pushExp(0, 32'd8, 1'b0, 1'b0);
        tick();
        reqValid = 2'b00;
        nCompared++; if (rspValid !== 2'b00) begin nMismatched++; $display("[TB] FAIL single_exec_valid actual=%b required=00", rspValid); end
        nCompared++; if (aluA !== 32'd5 || aluB !== 32'd3 || aluOp !== 3'b010) begin nMismatched++; $display("[TB] FAIL single_alu_drive actual=%0d/%0d/%b required=5/3/010", aluA, aluB, aluOp); end
        tick();
        nCompared++; if (rspValid !== 2'b01) begin nMismatched++; $display("[TB] FAIL single_rsp_valid actual=%b required=01", rspValid); end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            nCompared++; if (rspC !== e.c || rspZero !== e.zero || rspErr !== e.err) begin nMismatched++; $display("[TB] FAIL single_result actual=%0d/%b/%b required=%0d/%b/%b", rspC, rspZero, rspErr, e.c, e.zero, e.err); end
        end
        ackResp(0);
        nCompared++; if (rspValid !== 2'b00) begin nMismatched++; $display("[TB] FAIL single_drop actual=%b required=00", rspValid); end
    endtask

    task automatic test_alu_ops();
        int          rTab[4] = '{0, 1, 0, 1};
        logic [31:0] aTab[4] = '{32'd7, 32'h0000_00F0, 32'd1, 32'h8000_0000};
        logic [31:0] bTab[4] = '{32'd7, 32'h0000_000F, 32'hFFFF_FFFF, 32'd1};
        logic [2:0]  oTab[4] = '{3'b110, 3'b000, 3'b111, 3'b111};
        logic [31:0] cTab[4] = '{32'd0, 32'd0, 32'd1, 32'd0};
        logic        zTab[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            bit g;
            bit rsp;
            exp_t e;
            runOp(rTab[t], aTab[t], bTab[t], oTab[t], cTab[t], zTab[t], 1'b0, g, rsp);
            nCompared++; if (!(g && rsp)) begin nMismatched++; $display("[TB] FAIL ops_handshake[%0d] actual=grant%0d/rsp%0d required=1/1", t, g, rsp); end
            if (rsp && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                nCompared++; if (rspValid !== (2'b01 << e.owner)) begin nMismatched++; $display("[TB] FAIL ops_owner[%0d] actual=%b required=%b", t, rspValid, 2'b01 << e.owner); end
                nCompared++; if (rspC !== e.c || rspZero !== e.zero || rspErr !== e.err) begin nMismatched++; $display("[TB] FAIL ops_result[%0d] actual=%h/%b/%b required=%h/%b/%b", t, rspC, rspZero, rspErr, e.c, e.zero, e.err); end
                ackResp(e.owner);
            end
            sbQ.delete();
        end
    endtask

    task automatic test_contention();
        reset = 1'b1;
        setReq(0, 32'd10, 32'd20, 3'b010);
        setReq(1, 32'd50, 32'd8, 3'b110);
        tick();
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            int   expW;
            int   got;
            bit   seen;
            exp_t e;
            expW = g % 2;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (reqReady != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            nCompared++; if (reqReady !== (2'b01 << expW)) begin nMismatched++; $display("[TB] FAIL contention_grant[%0d] actual=%b required=%b", g, reqReady, 2'b01 << expW); end
            if (!seen) break;
            got = reqReady[1] ? 1 : 0;
            if (got == 0) pushExp(0, 32'd30, 1'b0, 1'b0);
            else          pushExp(1, 32'd42, 1'b0, 1'b0);
            tick();
            nCompared++; if (reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL contention_exec_ready[%0d] actual=%b required=00", g, reqReady); end
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rspValid != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            nCompared++; if (!seen) begin nMismatched++; $display("[TB] FAIL contention_timeout[%0d] actual=no_response required=response", g); end
            if (seen && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                nCompared++; if (rspValid !== (2'b01 << e.owner) || rspC !== e.c) begin nMismatched++; $display("[TB] FAIL contention_rsp[%0d] actual=%b/%0d required=%b/%0d", g, rspValid, rspC, 2'b01 << e.owner, e.c); end
                nCompared++; if (reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL contention_resp_ready[%0d] actual=%b required=00", g, reqReady); end
                rspReady = rspValid;
                tick();
                rspReady = 2'b00;
            end
        end
        reqValid = 2'b00;
        sbQ.delete();
        tick();
    endtask

    task automatic test_back_to_back();
        bit   g;
        bit   rsp;
        exp_t e;
        runOp(1, 32'h0000_00A0, 32'h0000_0005, 3'b001, 32'h0000_00A5, 1'b0, 1'b0, g, rsp);
        nCompared++; if (!(g && rsp)) begin nMismatched++; $display("[TB] FAIL bp_handshake actual=grant%0d/rsp%0d required=1/1", g, rsp); end
        if (sbQ.size() > 0) e = sbQ.pop_front();
        else begin e.owner = 1; e.c = 32'h0000_00A5; e.zero = 1'b0; e.err = 1'b0; end
        setReq(0, 32'd1, 32'd1, 3'b010);
        rspReady = 2'b01;
        for (int i = 0; i < 10; i++) begin
            #1;
            nCompared++; if (rspValid !== 2'b10 || rspC !== e.c) begin nMismatched++; $display("[TB] FAIL bp_hold[%0d] actual=%b/%h required=10/%h", i, rspValid, rspC, e.c); end
            nCompared++; if (reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL bp_ready[%0d] actual=%b required=00", i, reqReady); end
            tick();
        end
        rspReady = 2'b10;
        tick();
        rspReady = 2'b00;
        #1;
        nCompared++; if (rspValid !== 2'b00) begin nMismatched++; $display("[TB] FAIL bp_release actual=%b required=00", rspValid); end
        nCompared++; if (reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL bp_next_grant actual=%b required=01", reqReady); end
        if (reqReady == 2'b01) begin
            pushExp(0, 32'd2, 1'b0, 1'b0);
            tick();
        end
        reqValid = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (rspValid[0]) break;
            tick();
        end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            nCompared++; if (rspValid !== 2'b01 || rspC !== e.c) begin nMismatched++; $display("[TB] FAIL bp_followup actual=%b/%0d required=01/%0d", rspValid, rspC, e.c); end
            ackResp(0);
        end
    endtask

    task automatic test_reset_in_resp();
        bit   g;
        bit   rsp;
        exp_t e;
        runOp(0, 32'd9, 32'd4, 3'b110, 32'd5, 1'b0, 1'b0, g, rsp);
        nCompared++; if (rspValid !== 2'b01) begin nMismatched++; $display("[TB] FAIL rst_pre_valid actual=%b required=01", rspValid); end
        reset = 1'b1;
        tick();
        sbQ.delete();
        nCompared++; if (rspValid !== 2'b00 || rspC !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_abort actual=%b/%h required=00/0", rspValid, rspC); end
        reset = 1'b0;
        setReq(0, 32'd12, 32'd3, 3'b001);
        setReq(1, 32'd1, 32'd2, 3'b010);
        #1;
        nCompared++; if (reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL rst_next_grant actual=%b required=01", reqReady); end
        if (reqReady == 2'b01) begin
            pushExp(0, 32'd15, 1'b0, 1'b0);
            tick();
        end
        reqValid = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (rspValid[0]) break;
            tick();
        end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            nCompared++; if (rspValid !== 2'b01 || rspC !== e.c) begin nMismatched++; $display("[TB] FAIL rst_followup actual=%b/%0d required=01/%0d", rspValid, rspC, e.c); end
            ackResp(0);
        end
    endtask

    task automatic test_illegal_op();
        exp_t e;
        setReq(0, 32'd3, 32'd4, 3'b100);
        #1;
        nCompared++; if (reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL illegal_grant actual=%b required=01", reqReady); end
`ifdef ALU_SHARE_ILLEGAL_OP_EN
        pushExp(0, 32'h0, 1'b1, 1'b1);
        tick();
        reqValid = 2'b00;
        nCompared++; if (rspValid !== 2'b01) begin nMismatched++; $display("[TB] FAIL illegal_fast_valid actual=%b required=01", rspValid); end
        nCompared++; if (aluOp !== 3'b001) begin nMismatched++; $display("[TB] FAIL illegal_alu_op_kept actual=%b required=001", aluOp); end
`else
        pushExp(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        reqValid = 2'b00;
        nCompared++; if (rspValid !== 2'b00 || aluOp !== 3'b100) begin nMismatched++; $display("[TB] FAIL illegal_exec actual=%b/%b required=00/100", rspValid, aluOp); end
        tick();
        nCompared++; if (rspValid !== 2'b01) begin nMismatched++; $display("[TB] FAIL illegal_valid actual=%b required=01", rspValid); end
`endif
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            nCompared++; if (rspC !== e.c || rspZero !== e.zero || rspErr !== e.err) begin nMismatched++; $display("[TB] FAIL illegal_result actual=%h/%b/%b required=%h/%b/%b", rspC, rspZero, rspErr, e.c, e.zero, e.err); end
        end
        ackResp(0);
    endtask

    // Sequence every scenario, then report.
    initial begin
        test_reset();
        test_single_op();
        test_alu_ops();
        test_contention();
        test_back_to_back();
        test_reset_in_resp();
        test_illegal_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
